// File: rtl/zbuf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : zbuf_pkg                                                 |
// | Description : Shared Z-buffer definitions: screen geometry, entry      |
// |               count, clear depth, word typedefs and controller states. |
// |               The pixel iterator uses ZB_WIDTH for address arithmetic. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package zbuf_pkg;

  localparam int ADDR_W     = 17;
  localparam int DEPTH_W    = 16;
  localparam int ZB_WIDTH   = 320;
  localparam int ZB_HEIGHT  = 240;
  localparam int NUM_PIXELS = ZB_WIDTH * ZB_HEIGHT;

  // Far plane: every entry holds this after a clear.
  localparam logic [DEPTH_W-1:0] CLEAR_VAL = 16'hFFFF;

  typedef logic [ADDR_W-1:0]  zaddr_t;
  typedef logic [DEPTH_W-1:0] depth_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } zbuf_state_t;

endpackage
`default_nettype wire

// File: rtl/zbuf_fwd_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : zbuf_fwd_pipe                                            |
// | Description : Two-stage Z read return pipeline with write forwarding.  |
// |               Stage 1 tracks the request while the BRAM reads; stage 2 |
// |               registers the returned depth. Writes hitting an          |
// |               in-flight read replace the (read-first, stale) BRAM data.|
// | Revision    : 1.0 - initial release                                    |
// |                                                                        |
// | Ports:                                                                 |
// |   clk, rst             clock, async active-high reset                  |
// |   req_valid/addr/oor   accepted read request, oor = out of range       |
// |   wr_en/addr/data      write actually issued to the BRAM this cycle    |
// |   mem_rdata            BRAM read data (one cycle after request)        |
// |   out_valid/addr/data  registered read response (request + 2)          |
// +------------------------------------------------------------------------+
module zbuf_fwd_pipe #(
  parameter int                 ADDR_W    = zbuf_pkg::ADDR_W,
  parameter int                 DEPTH_W   = zbuf_pkg::DEPTH_W,
  parameter logic [DEPTH_W-1:0] CLEAR_VAL = zbuf_pkg::CLEAR_VAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_oor,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DEPTH_W-1:0] wr_data,
  input  logic [DEPTH_W-1:0] mem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [DEPTH_W-1:0] out_data
);

  logic               r_s1_valid;
  logic [ADDR_W-1:0]  r_s1_addr;
  logic               r_s1_oor;
  logic               r_s1_hit;
  logic [DEPTH_W-1:0] r_s1_wdata;
  logic [DEPTH_W-1:0] w_ret_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_oor   <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s1_wdata <= '0;
    end else begin
      r_s1_valid <= req_valid;
      r_s1_addr  <= req_addr;
      r_s1_oor   <= req_oor;
      // Same-cycle write: the read-first BRAM returns the old word.
      r_s1_hit   <= req_valid && wr_en && (wr_addr == req_addr);
      r_s1_wdata <= wr_data;
    end
  end

  // Priority: out-of-range > write in the data cycle > write in the request cycle.
  always_comb begin
    w_ret_data = mem_rdata;
    if (r_s1_oor)
      w_ret_data = CLEAR_VAL;
    else if (wr_en && (wr_addr == r_s1_addr))
      w_ret_data = wr_data;
    else if (r_s1_hit)
      w_ret_data = r_s1_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_addr <= r_s1_addr;
        out_data <= w_ret_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/zbuffer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : zbuffer_ctrl                                             |
// | Description : Z-buffer memory controller between the raster pipeline   |
// |               and a simple-dual-port depth BRAM. Services one read per |
// |               cycle at fixed latency 2, passes depth write-backs       |
// |               through, and runs the frame-start clear sequence.        |
// | Revision    : 1.0 - initial release                                    |
// | Option      : ZBUF_STATS_EN builds the read/write service counters;    |
// |               without it o_rd_count/o_wr_count are tied to zero.       |
// |                                                                        |
// | Ports:                                                                 |
// |   i_clk, i_rst            clock, async active-high reset               |
// |   i_clear                 start clear; o_busy during, o_clear_done end |
// |   i_rd_valid/addr         read request; o_rd_valid/addr/data response  |
// |   i_wr_valid/addr/data    depth write-back                             |
// |   o_mem_re/raddr          BRAM read port, i_mem_rdata one cycle later  |
// |   o_mem_we/waddr/wdata    BRAM write port                              |
// |   o_err                   sticky drop / out-of-range flag              |
// |   o_rd_count, o_wr_count  service counters (optional)                  |
// +------------------------------------------------------------------------+
module zbuffer_ctrl #(
  parameter int                 ADDR_W     = zbuf_pkg::ADDR_W,
  parameter int                 DEPTH_W    = zbuf_pkg::DEPTH_W,
  parameter int                 NUM_PIXELS = zbuf_pkg::NUM_PIXELS,
  parameter logic [DEPTH_W-1:0] CLEAR_VAL  = zbuf_pkg::CLEAR_VAL
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  output logic               o_busy,
  output logic               o_clear_done,
  input  logic               i_rd_valid,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic               o_rd_valid,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic [DEPTH_W-1:0] o_rd_data,
  input  logic               i_wr_valid,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [DEPTH_W-1:0] i_wr_data,
  output logic               o_mem_re,
  output logic [ADDR_W-1:0]  o_mem_raddr,
  input  logic [DEPTH_W-1:0] i_mem_rdata,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_waddr,
  output logic [DEPTH_W-1:0] o_mem_wdata,
  output logic               o_err,
  output logic [31:0]        o_rd_count,
  output logic [31:0]        o_wr_count
);

  import zbuf_pkg::*;

  localparam logic [ADDR_W-1:0] c_num_pix   = ADDR_W'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_PIXELS - 1);

  zbuf_state_t       r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_busy;
  logic              r_clear_done;
  logic              r_err;

  logic w_clearing;
  logic w_rd_in;
  logic w_wr_in;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_err_evt;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_rd_in    = (i_rd_addr < c_num_pix);
  assign w_wr_in    = (i_wr_addr < c_num_pix);

  // Reads outside CLEAR always enter the return pipe; only in-range ones touch the BRAM.
  assign w_rd_acc = i_rd_valid && !w_clearing;
  assign w_wr_acc = i_wr_valid && !w_clearing && w_wr_in;

  assign w_err_evt = (i_rd_valid && (w_clearing || !w_rd_in)) ||
                     (i_wr_valid && (w_clearing || !w_wr_in));

  assign o_mem_re    = w_rd_acc && w_rd_in;
  assign o_mem_raddr = o_mem_re ? i_rd_addr : '0;

  // The clear owns the write port; user writes are locked out while it runs.
  assign o_mem_we    = w_clearing || w_wr_acc;
  assign o_mem_waddr = w_clearing ? r_clr_addr : (w_wr_acc ? i_wr_addr : '0);
  assign o_mem_wdata = w_clearing ? CLEAR_VAL  : (w_wr_acc ? i_wr_data : '0);

  assign o_busy       = r_busy;
  assign o_clear_done = r_clear_done;
  assign o_err        = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_clr_addr   <= '0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_state    <= ST_CLEAR;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == c_last_addr) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
            r_clr_addr   <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_err_evt)
        r_err <= 1'b1;
    end
  end

  // Forwarding looks at the real BRAM write port, so clear writes are also
  // reflected in a read that was issued just before the clear began.
  zbuf_fwd_pipe #(
    .ADDR_W    (ADDR_W),
    .DEPTH_W   (DEPTH_W),
    .CLEAR_VAL (CLEAR_VAL)
  ) u_fwd_pipe (
    .clk       (i_clk),
    .rst       (i_rst),
    .req_valid (w_rd_acc),
    .req_addr  (i_rd_addr),
    .req_oor   (!w_rd_in),
    .wr_en     (o_mem_we),
    .wr_addr   (o_mem_waddr),
    .wr_data   (o_mem_wdata),
    .mem_rdata (i_mem_rdata),
    .out_valid (o_rd_valid),
    .out_addr  (o_rd_addr),
    .out_data  (o_rd_data)
  );

`ifdef ZBUF_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if ((r_state == ST_IDLE) && i_clear) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (o_rd_valid && (r_rd_count != 32'hFFFF_FFFF))
        r_rd_count <= r_rd_count + 32'd1;
      if (w_wr_acc && (r_wr_count != 32'hFFFF_FFFF))
        r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`else
  assign o_rd_count = '0;
  assign o_wr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zbuffer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : tb_zbuffer_ctrl                                          |
// | Description : Directed self-checking bench for zbuffer_ctrl with a     |
// |               behavioural read-first, 1-cycle-latency depth BRAM.      |
// | Revision    : 1.0 - initial release                                    |
// | Option      : ZBUF_STATS_EN selects the expected counter values.       |
// +------------------------------------------------------------------------+
module tb_zbuffer_ctrl;

  localparam int AW   = 17;
  localparam int DW   = 16;
  localparam int NPIX = 76800;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_clear = 1'b0;
  logic          i_rd_valid = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          i_wr_valid = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic [DW-1:0] i_mem_rdata;

  logic          o_busy, o_clear_done, o_rd_valid, o_mem_re, o_mem_we, o_err;
  logic [AW-1:0] o_rd_addr, o_mem_raddr, o_mem_waddr;
  logic [DW-1:0] o_rd_data, o_mem_wdata;
  logic [31:0]   o_rd_count, o_wr_count;

  logic [DW-1:0] mem [0:NPIX-1];

  int n_vec = 0;
  int n_err = 0;

  zbuffer_ctrl dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_clear_done (o_clear_done),
    .i_rd_valid   (i_rd_valid),
    .i_rd_addr    (i_rd_addr),
    .o_rd_valid   (o_rd_valid),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .i_wr_valid   (i_wr_valid),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_mem_re     (o_mem_re),
    .o_mem_raddr  (o_mem_raddr),
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_we     (o_mem_we),
    .o_mem_waddr  (o_mem_waddr),
    .o_mem_wdata  (o_mem_wdata),
    .o_err        (o_err),
    .o_rd_count   (o_rd_count),
    .o_wr_count   (o_wr_count)
  );

  always #5 i_clk = ~i_clk;

  // Read-first BRAM: the read samples the array before this edge's write lands.
  always @(posedge i_clk) begin
    if (o_mem_re && o_mem_raddr < AW'(NPIX)) i_mem_rdata <= mem[o_mem_raddr];
    if (o_mem_we && o_mem_waddr < AW'(NPIX)) mem[o_mem_waddr] <= o_mem_wdata;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_vec++; if ({o_busy, o_clear_done, o_rd_valid, o_err} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {o_busy, o_clear_done, o_rd_valid, o_err}); end
    i_rst = 1'b0;
    step();
    n_vec++; if ({o_mem_re, o_mem_we, o_mem_raddr, o_mem_waddr, o_mem_wdata, o_rd_addr, o_rd_data} !== '0) begin n_err++; $display("FAIL reset_bus: got nonzero memory/read bus, want 0"); end
    n_vec++; if ({o_rd_count, o_wr_count} !== 64'd0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", o_rd_count, o_wr_count); end
  endtask

  task automatic test_clear_abort();
    i_clear = 1'b1; step(); i_clear = 1'b0;
    n_vec++; if ({o_busy, o_mem_we, o_mem_waddr, o_mem_wdata} !== {2'b11, 17'd0, 16'hFFFF}) begin n_err++; $display("FAIL clr_first: busy=%b we=%b addr=%0d data=%h want 1 1 0 ffff", o_busy, o_mem_we, o_mem_waddr, o_mem_wdata); end
    repeat (100) step();
    n_vec++; if (o_mem_waddr !== 17'd100) begin n_err++; $display("FAIL clr_addr100: got %0d want 100", o_mem_waddr); end
    // Requests while clearing are dropped and flagged.
    i_rd_valid = 1'b1; i_rd_addr = 17'd10;
    i_wr_valid = 1'b1; i_wr_addr = 17'd11; i_wr_data = 16'h1111;
    #1;
    n_vec++; if ({o_mem_re, o_mem_waddr, o_mem_wdata} !== {1'b0, 17'd100, 16'hFFFF}) begin n_err++; $display("FAIL clr_drop_req: re=%b addr=%0d data=%h want 0 100 ffff", o_mem_re, o_mem_waddr, o_mem_wdata); end
    step(); i_rd_valid = 1'b0; i_wr_valid = 1'b0;
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL clr_err: got %b want 1", o_err); end
    step();
    n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_no_rdvalid: got %b want 0", o_rd_valid); end
    // Asynchronous reset in the middle of the clock period.
    #2 i_rst = 1'b1;
    #1;
    n_vec++; if ({o_busy, o_clear_done, o_mem_we, o_mem_waddr, o_mem_wdata, o_err, o_rd_valid} !== '0) begin n_err++; $display("FAIL async_reset: busy=%b we=%b waddr=%0d err=%b want all 0", o_busy, o_mem_we, o_mem_waddr, o_err); end
    #2 i_rst = 1'b0;
    step();
    n_vec++; if ({o_busy, o_mem_we} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle: busy=%b we=%b want 0 0", o_busy, o_mem_we); end
  endtask

  task automatic test_full_clear();
    int n;
    int bad;
    int done_cnt;
    n = 0; bad = 0; done_cnt = 0;
    i_clear = 1'b1; step(); i_clear = 1'b0;
    for (int c = 0; c < 80000; c++) begin
      if (o_busy === 1'b1) begin
        if (o_mem_we !== 1'b1 || o_mem_waddr !== AW'(n) || o_mem_wdata !== 16'hFFFF) bad++;
        n++;
      end
      if (o_clear_done === 1'b1) begin
        if (o_busy !== 1'b0) bad++;
        done_cnt++;
        break;
      end
      step();
    end
    n_vec++; if (n !== NPIX) begin n_err++; $display("FAIL clear_busy_cycles: got %0d want %0d", n, NPIX); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL clear_writes: got %0d bad cycles want 0", bad); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL clear_done_seen: got %0d want 1", done_cnt); end
    step();
    n_vec++; if ({o_clear_done, o_busy, o_mem_we} !== 3'b000) begin n_err++; $display("FAIL clear_done_pulse: done=%b busy=%b we=%b want 0 0 0", o_clear_done, o_busy, o_mem_we); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
`ifdef ZBUF_STATS_EN
    exp_rd = 32'd10; exp_wr = 32'd4;
`else
    exp_rd = 32'd0;  exp_wr = 32'd0;
`endif
    for (int i = 0; i < 10; i++) begin
      i_rd_valid = 1'b1; i_rd_addr = AW'(100 + i); step();
    end
    i_rd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      i_wr_valid = 1'b1; i_wr_addr = AW'(200 + i); i_wr_data = DW'(16'h0200 + i); step();
    end
    i_wr_valid = 1'b0;
    repeat (3) step();
    n_vec++; if (o_rd_count !== exp_rd) begin n_err++; $display("FAIL stats_rd: got %0d want %0d", o_rd_count, exp_rd); end
    n_vec++; if (o_wr_count !== exp_wr) begin n_err++; $display("FAIL stats_wr: got %0d want %0d", o_wr_count, exp_wr); end
  endtask

  task automatic test_read_after_clear();
    i_rd_valid = 1'b1; i_rd_addr = 17'd1234;
    #1;
    n_vec++; if ({o_mem_re, o_mem_raddr} !== {1'b1, 17'd1234}) begin n_err++; $display("FAIL rd1234_bram: re=%b addr=%0d want 1 1234", o_mem_re, o_mem_raddr); end
    step(); i_rd_valid = 1'b0;
    n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL rd1234_early: got %b want 0", o_rd_valid); end
    step();
    n_vec++; if ({o_rd_valid, o_rd_addr, o_rd_data} !== {1'b1, 17'd1234, 16'hFFFF}) begin n_err++; $display("FAIL rd1234_resp: v=%b a=%0d d=%h want 1 1234 ffff", o_rd_valid, o_rd_addr, o_rd_data); end
  endtask

  task automatic test_write_read();
    i_wr_valid = 1'b1; i_wr_addr = 17'd5; i_wr_data = 16'h1000;
    #1;
    n_vec++; if ({o_mem_we, o_mem_waddr, o_mem_wdata} !== {1'b1, 17'd5, 16'h1000}) begin n_err++; $display("FAIL wr5_pass: we=%b a=%0d d=%h want 1 5 1000", o_mem_we, o_mem_waddr, o_mem_wdata); end
    step(); i_wr_valid = 1'b0;
    repeat (3) step();
    i_rd_valid = 1'b1; i_rd_addr = 17'd5;
    step(); i_rd_valid = 1'b0;
    step();
    n_vec++; if ({o_rd_valid, o_rd_addr, o_rd_data} !== {1'b1, 17'd5, 16'h1000}) begin n_err++; $display("FAIL rd5_resp: v=%b a=%0d d=%h want 1 5 1000", o_rd_valid, o_rd_addr, o_rd_data); end
  endtask

  task automatic test_forward();
    // Write in the cycle after the read.
    i_rd_valid = 1'b1; i_rd_addr = 17'd7; step(); i_rd_valid = 1'b0;
    i_wr_valid = 1'b1; i_wr_addr = 17'd7; i_wr_data = 16'h0042; step(); i_wr_valid = 1'b0;
    n_vec++; if ({o_rd_valid, o_rd_data} !== {1'b1, 16'h0042}) begin n_err++; $display("FAIL fwd_t1: v=%b d=%h want 1 0042", o_rd_valid, o_rd_data); end
    // Writes in both cycles: the later one wins.
    i_rd_valid = 1'b1; i_rd_addr = 17'd7; i_wr_valid = 1'b1; i_wr_addr = 17'd7; i_wr_data = 16'h0010;
    step(); i_rd_valid = 1'b0; i_wr_data = 16'h0020;
    step(); i_wr_valid = 1'b0;
    n_vec++; if ({o_rd_valid, o_rd_data} !== {1'b1, 16'h0020}) begin n_err++; $display("FAIL fwd_both: v=%b d=%h want 1 0020", o_rd_valid, o_rd_data); end
    // Write in the same cycle only (BRAM alone would return 0x0020).
    i_rd_valid = 1'b1; i_rd_addr = 17'd7; i_wr_valid = 1'b1; i_wr_addr = 17'd7; i_wr_data = 16'h0030;
    step(); i_rd_valid = 1'b0; i_wr_valid = 1'b0;
    step();
    n_vec++; if ({o_rd_valid, o_rd_data} !== {1'b1, 16'h0030}) begin n_err++; $display("FAIL fwd_t0: v=%b d=%h want 1 0030", o_rd_valid, o_rd_data); end
    // Write to a different address must not forward.
    i_rd_valid = 1'b1; i_rd_addr = 17'd7; step(); i_rd_valid = 1'b0;
    i_wr_valid = 1'b1; i_wr_addr = 17'd8; i_wr_data = 16'h0999; step(); i_wr_valid = 1'b0;
    n_vec++; if ({o_rd_valid, o_rd_data} !== {1'b1, 16'h0030}) begin n_err++; $display("FAIL fwd_miss: v=%b d=%h want 1 0030", o_rd_valid, o_rd_data); end
  endtask

  task automatic test_back_to_back();
    int bad;
    int exp_a;
    logic [DW-1:0] exp_d;
    bad = 0;
    i_wr_valid = 1'b1; i_wr_addr = 17'd700; i_wr_data = 16'hABCD; step(); i_wr_valid = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 322; i++) begin
      if (i < 320) begin i_rd_valid = 1'b1; i_rd_addr = AW'(640 + i); end
      else i_rd_valid = 1'b0;
      step();
      if (i >= 1 && i <= 320) begin
        exp_a = 640 + i - 1;
        exp_d = (exp_a == 700) ? 16'hABCD : 16'hFFFF;
        if (o_rd_valid !== 1'b1 || o_rd_addr !== AW'(exp_a) || o_rd_data !== exp_d) bad++;
      end
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL burst_stream: got %0d bad responses want 0", bad); end
    n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL burst_tail: got %b want 0", o_rd_valid); end
  endtask

  task automatic test_out_of_range();
    n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL oor_err_pre: got %b want 0", o_err); end
    i_wr_valid = 1'b1; i_wr_addr = 17'd80000; i_wr_data = 16'h1234;
    #1;
    n_vec++; if (o_mem_we !== 1'b0) begin n_err++; $display("FAIL oor_wr_drop: got %b want 0", o_mem_we); end
    step(); i_wr_valid = 1'b0;
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %b want 1", o_err); end
    i_rd_valid = 1'b1; i_rd_addr = 17'd76800;
    #1;
    n_vec++; if (o_mem_re !== 1'b0) begin n_err++; $display("FAIL oor_rd_nobram: got %b want 0", o_mem_re); end
    step(); i_rd_valid = 1'b0;
    step();
    n_vec++; if ({o_rd_valid, o_rd_addr, o_rd_data} !== {1'b1, 17'd76800, 16'hFFFF}) begin n_err++; $display("FAIL oor_rd_resp: v=%b a=%0d d=%h want 1 76800 ffff", o_rd_valid, o_rd_addr, o_rd_data); end
    repeat (5) step();
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL oor_err_sticky: got %b want 1", o_err); end
  endtask

  task automatic test_final_reset();
    i_rst = 1'b1; step(); i_rst = 1'b0; step();
    n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", o_err); end
  endtask

  initial begin
    test_reset();
    test_clear_abort();
    test_full_clear();
    test_stats();
    test_read_after_clear();
    test_write_read();
    test_forward();
    test_back_to_back();
    test_out_of_range();
    test_final_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
